frame_packer: RTL and testbench

FRAME_PACKER -- requirements
Module: frame_packer

---
 rtl/vibrometer_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/frame_packer.sv | 102 ++++++++++
 tb/tb_frame_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vibrometer_pkg.sv
// Shared types and constants for the vibrometer stream blocks.
package vibrometer_pkg;

  localparam int FP_AXIS_TDATA_WIDTH = 32;
  localparam int FP_MAX_LOG_LENGTH   = 16;
  localparam int FP_CNT_WIDTH        = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fp_state_t;

  // Limit a requested log2 frame length to the largest supported frame.
  function automatic logic [4:0] fp_clamp_log_length(input logic [4:0] log_length);
    return (log_length > 5'(FP_MAX_LOG_LENGTH)) ? 5'(FP_MAX_LOG_LENGTH) : log_length;
  endfunction

  // Index of the final beat of a frame of 2^log_length beats.
  function automatic logic [FP_CNT_WIDTH-1:0] fp_last_index(input logic [4:0] log_length);
    return (FP_CNT_WIDTH'(1) << log_length) - FP_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible on
// rd_data whenever empty is low. Writes to a full FIFO and reads from an
// empty FIFO are ignored.
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_q;
  logic [LOG_DEPTH:0] rd_ptr_q;
  logic               do_wr;
  logic               do_rd;

  // The extra MSB tells a full FIFO (same index, different lap) from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_q[LOG_DEPTH-1:0]];

  // Advance read/write pointers; they wrap naturally modulo 2^(LOG_DEPTH+1).
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + {{LOG_DEPTH{1'b0}}, 1'b1};
      if (do_rd) rd_ptr_q <= rd_ptr_q + {{LOG_DEPTH{1'b0}}, 1'b1};
    end
  end

  // Store accepted words.
  // NOTE: storage is deliberately not reset; emptiness comes from the pointers alone.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr_q[LOG_DEPTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_packer.sv
// Cuts the averager stream into frames of 2^L beats, buffers them in a FWFT
// FIFO and marks the last beat of each frame with tlast. Once started, an
// input frame is always completed before returning to IDLE, so the buffer
// only ever holds whole frames unless a reset discards one.
module frame_packer
  import vibrometer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = FP_AXIS_TDATA_WIDTH,
  parameter int FIFO_LOG_DEPTH   = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        FP_enable,
  input  logic [4:0]                  FP_log_length,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic [15:0]                 FP_overflow_count,
  output logic [15:0]                 FP_frame_count
);

  fp_state_t                   state_q;
  fp_state_t                   state_d;
  logic [4:0]                  log_len_q;
  logic [FP_CNT_WIDTH-1:0]     last_idx;
  logic [FP_CNT_WIDTH-1:0]     in_cnt_q;
  logic [FP_CNT_WIDTH-1:0]     in_cnt_d;
  logic [FP_CNT_WIDTH-1:0]     out_cnt_q;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [AXIS_TDATA_WIDTH-1:0] fifo_rd_data;
  logic                        s_fire;
  logic                        m_fire;
  logic                        in_last;
  logic                        out_last;
  logic                        overflow;

  assign last_idx      = fp_last_index(log_len_q);
  assign S_AXIS_tready = !areset && ((state_q == IDLE) || !fifo_full);
  assign s_fire        = (state_q != IDLE) && S_AXIS_tvalid && S_AXIS_tready;
  assign overflow      = (state_q != IDLE) && S_AXIS_tvalid && !S_AXIS_tready;
  assign in_last       = (in_cnt_q == last_idx);
  assign out_last      = (out_cnt_q == last_idx);
  assign M_AXIS_tvalid = !fifo_empty;
  assign M_AXIS_tdata  = fifo_empty ? '0 : fifo_rd_data;
  assign M_AXIS_tlast  = !fifo_empty && out_last;
  assign m_fire        = M_AXIS_tvalid && M_AXIS_tready;

  sync_fifo #(
    .WIDTH     (AXIS_TDATA_WIDTH),
    .LOG_DEPTH (FIFO_LOG_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (s_fire),
    .wr_data (S_AXIS_tdata),
    .full    (fifo_full),
    .rd_en   (M_AXIS_tready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  // Next input beat index and next control state. Leaving RUN looks at the
  // count after this cycle's beat, so a frame finishing right now goes to IDLE.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    in_cnt_d = in_cnt_q;
    state_d  = state_q;
    if (s_fire) in_cnt_d = in_last ? '0 : in_cnt_q + FP_CNT_WIDTH'(1);
    unique case (state_q)
      IDLE:    if (FP_enable) state_d = RUN;
      RUN:     if (!FP_enable) state_d = (in_cnt_d == '0) ? IDLE : STOP;
      STOP:    if (s_fire && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, frame length latch, beat counters and status counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q           <= IDLE;
      log_len_q         <= '0;
      in_cnt_q          <= '0;
      out_cnt_q         <= '0;
      FP_overflow_count <= '0;
      FP_frame_count    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      if ((state_q == IDLE) && FP_enable) log_len_q <= fp_clamp_log_length(FP_log_length);
      if (m_fire) out_cnt_q <= out_last ? '0 : out_cnt_q + FP_CNT_WIDTH'(1);
      if (m_fire && out_last) FP_frame_count <= FP_frame_count + 16'd1;
      if (overflow && (FP_overflow_count != 16'hFFFF))
        FP_overflow_count <= FP_overflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer with a scoreboard: accepted input beats are
// queued with their expected tlast and compared as output beats transfer.
module tb_frame_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        FP_enable;
  logic [4:0]  FP_log_length;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        M_AXIS_tlast;
  logic [15:0] FP_overflow_count;
  logic [15:0] FP_frame_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (0 idle, 1 run, 2 stop)
  logic [32:0] sb [$];
  int          m_state;
  int          m_L;
  int          m_in;
  logic [15:0] m_frames;
  logic [15:0] m_ovf;
  logic [15:0] src_a;
  logic        hs;

  frame_packer #(
    .AXIS_TDATA_WIDTH (32),
    .FIFO_LOG_DEPTH   (4)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .FP_enable         (FP_enable),
    .FP_log_length     (FP_log_length),
    .S_AXIS_tdata      (S_AXIS_tdata),
    .S_AXIS_tvalid     (S_AXIS_tvalid),
    .S_AXIS_tready     (S_AXIS_tready),
    .M_AXIS_tdata      (M_AXIS_tdata),
    .M_AXIS_tvalid     (M_AXIS_tvalid),
    .M_AXIS_tready     (M_AXIS_tready),
    .M_AXIS_tlast      (M_AXIS_tlast),
    .FP_overflow_count (FP_overflow_count),
    .FP_frame_count    (FP_frame_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock cycles; the source moves to its next word after each handshake.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      hs = S_AXIS_tvalid && S_AXIS_tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        src_a        = src_a + 16'd1;
        S_AXIS_tdata = {src_a + 16'd1, src_a};
      end
    end
  endtask

  task automatic restart_source();
    src_a        = 16'd0;
    S_AXIS_tdata = 32'h0001_0000;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    FP_enable     = 1'b0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b0;
    restart_source();
    tick(2);
    check("reset_s_tready", 64'(S_AXIS_tready), 64'(0));
    areset = 1'b0;
  endtask

  // Mid-cycle model: check DUT against the model, then apply the coming edge to the model.
  always @(negedge aclk) begin : model
    logic        exp_ready;
    logic        accept;
    logic        wrapped;
    logic [32:0] ent;
    int          last;
    if (areset) begin
      check("s_tready_in_reset", 64'(S_AXIS_tready), 64'(0));
      sb.delete();
      m_state  = 0;
      m_L      = 0;
      m_in     = 0;
      m_frames = 16'd0;
      m_ovf    = 16'd0;
    end else begin
      last      = (1 << m_L) - 1;
      exp_ready = (m_state == 0) ? 1'b1 : (sb.size() < 16);
      check("s_tready", 64'(S_AXIS_tready), 64'(exp_ready));
      check("m_tvalid", 64'(M_AXIS_tvalid), 64'(sb.size() != 0));
      check("frame_count", 64'(FP_frame_count), 64'(m_frames));
      check("overflow_count", 64'(FP_overflow_count), 64'(m_ovf));
      if (M_AXIS_tvalid && M_AXIS_tready && sb.size() != 0) begin
        ent = sb.pop_front();
        check("m_tdata", 64'(M_AXIS_tdata), 64'(ent[31:0]));
        check("m_tlast", 64'(M_AXIS_tlast), 64'(ent[32]));
        if (ent[32]) m_frames = m_frames + 16'd1;
      end else if (sb.size() == 0) begin
        check("empty_tdata", 64'(M_AXIS_tdata), 64'(0));
        check("empty_tlast", 64'(M_AXIS_tlast), 64'(0));
      end
      accept  = (m_state != 0) && S_AXIS_tvalid && exp_ready;
      wrapped = 1'b0;
      if ((m_state != 0) && S_AXIS_tvalid && !exp_ready && m_ovf != 16'hFFFF)
        m_ovf = m_ovf + 16'd1;
      if (accept) begin
        sb.push_back({1'(m_in == last), S_AXIS_tdata});
        if (m_in == last) begin
          m_in    = 0;
          wrapped = 1'b1;
        end else begin
          m_in = m_in + 1;
        end
      end
      case (m_state)
        0: if (FP_enable) begin
             m_state = 1;
             m_L     = (int'(FP_log_length) > 16) ? 16 : int'(FP_log_length);
           end
        1: if (!FP_enable) m_state = (m_in == 0) ? 0 : 2;
        2: if (accept && wrapped) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  initial begin
    FP_log_length = 5'd0;
    do_reset();
    #1;
    check("post_reset_s_tready", 64'(S_AXIS_tready), 64'(1));
    check("post_reset_m_tvalid", 64'(M_AXIS_tvalid), 64'(0));
    check("post_reset_m_tlast", 64'(M_AXIS_tlast), 64'(0));
    check("post_reset_m_tdata", 64'(M_AXIS_tdata), 64'(0));
    check("post_reset_frames", 64'(FP_frame_count), 64'(0));
    check("post_reset_ovf", 64'(FP_overflow_count), 64'(0));

    // Streaming, L=2: tlast on beats 3, 7, 11.
    FP_log_length = 5'd2;
    FP_enable     = 1'b1;
    M_AXIS_tready = 1'b1;
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(1);
    check("first_word_tdata", 64'(M_AXIS_tdata), 64'(32'h0001_0000));
    check("first_word_tvalid", 64'(M_AXIS_tvalid), 64'(1));
    tick(11);
    S_AXIS_tvalid = 1'b0;
    tick(2);
    check("stream_frames", 64'(FP_frame_count), 64'(3));

    // Back-pressure, L=2: 40 run cycles, 16 accepted, 24 refused.
    do_reset();
    FP_log_length = 5'd2;
    FP_enable     = 1'b1;
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(40);
    check("bp_s_tready", 64'(S_AXIS_tready), 64'(0));
    check("bp_overflow", 64'(FP_overflow_count), 64'(24));
    check("bp_head_tdata", 64'(M_AXIS_tdata), 64'(32'h0001_0000));
    M_AXIS_tready = 1'b1;
    tick(24);
    check("bp_frames", 64'(FP_frame_count) >= 64'(4), 64'(1));

    // Stop mid-frame, L=3: beats 6 and 7 still taken, then IDLE.
    do_reset();
    FP_log_length = 5'd3;
    FP_enable     = 1'b1;
    M_AXIS_tready = 1'b1;
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(6);
    FP_enable = 1'b0;
    tick(2);
    check("stop_idle_s_tready", 64'(S_AXIS_tready), 64'(1));
    tick(3);
    check("stop_frames", 64'(FP_frame_count), 64'(1));
    check("stop_drained", 64'(M_AXIS_tvalid), 64'(0));

    // Reset with 5 words buffered, then single-beat frames.
    do_reset();
    FP_log_length = 5'd3;
    FP_enable     = 1'b1;
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(5);
    check("pre_reset_tvalid", 64'(M_AXIS_tvalid), 64'(1));
    areset = 1'b1;
    tick(1);
    check("mid_reset_tvalid", 64'(M_AXIS_tvalid), 64'(0));
    check("mid_reset_tlast", 64'(M_AXIS_tlast), 64'(0));
    check("mid_reset_ovf", 64'(FP_overflow_count), 64'(0));
    areset        = 1'b0;
    S_AXIS_tvalid = 1'b0;
    FP_log_length = 5'd0;
    M_AXIS_tready = 1'b1;
    restart_source();
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(1);
    check("l0_tlast", 64'(M_AXIS_tlast), 64'(1));
    tick(7);
    S_AXIS_tvalid = 1'b0;
    tick(2);
    check("l0_frames", 64'(FP_frame_count), 64'(8));

    // Oversized length clamps to 16; a mid-run length change is ignored.
    do_reset();
    FP_log_length = 5'd20;
    FP_enable     = 1'b1;
    M_AXIS_tready = 1'b1;
    tick(1);
    S_AXIS_tvalid = 1'b1;
    tick(10);
    FP_log_length = 5'd1;
    tick(65526);
    check("clamp_frames_before_last", 64'(FP_frame_count), 64'(0));
    S_AXIS_tvalid = 1'b0;
    FP_enable     = 1'b0;
    tick(2);
    check("clamp_frames", 64'(FP_frame_count), 64'(1));
    check("clamp_idle_s_tready", 64'(S_AXIS_tready), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
